// File: rtl/div8_loop.sv
// Iterative restoring fractional divider: q = floor(a*2^W / b), r = (a*2^W) mod b.
// Resolves one quotient bit per clock; saturates on divide-by-zero or a >= b.
//
// state  | meaning
// S_IDLE | waiting for start, results held
// S_RUN  | iterating, one quotient bit per cycle
module div8_loop #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] r_o,
   output logic         busy,
   output logic         done,
   output logic         ovf,
   output logic         dz
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_rem;
   logic [W-1:0]   r_quo;
   logic           r_dz;
   logic           r_ovf;

   logic           w_accept;
   logic           w_last;
   logic [W:0]     w_shift;
   logic [W:0]     w_diff;
   logic           w_qbit;
   logic [W-1:0]   w_rem_nxt;
   logic [W-1:0]   w_quo_nxt;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_state == S_RUN) && (r_cnt == '0);
   assign busy     = (r_state == S_RUN);

   // W+1-bit trial remainder; with a < b the difference stays within signed range,
   // so its top bit is a valid borrow.
   assign w_shift   = {r_rem, 1'b0};
   assign w_diff    = w_shift - {1'b0, r_b};
   assign w_qbit    = ~w_diff[W];
   assign w_rem_nxt = w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];

   always_comb begin
      w_quo_nxt = r_quo;
      for (int i = 0; i < W; i++) begin
         if (r_cnt == CW'(i)) w_quo_nxt[i] = w_qbit;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_cnt <= '0;
         r_dz  <= 1'b0;
         r_ovf <= 1'b0;
         q_o   <= '0;
         r_o   <= '0;
         done  <= 1'b0;
         ovf   <= 1'b0;
         dz    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (w_accept) begin
            r_a   <= a_i;
            r_b   <= b_i;
            // The upper W dividend bits are a itself; with a < b they yield only
            // zero quotient bits, so the partial remainder starts out equal to a.
            r_rem <= a_i;
            r_quo <= '0;
            r_cnt <= CW'(W - 1);
            r_dz  <= (b_i == '0);
            r_ovf <= (b_i != '0) && (a_i >= b_i);
         end else if (r_state == S_RUN) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (!w_last) r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
               done <= 1'b1;
               ovf  <= r_ovf;
               dz   <= r_dz;
               if (r_dz || r_ovf) begin
                  q_o <= '1;
                  r_o <= r_a;
               end else begin
                  q_o <= w_quo_nxt;
                  r_o <= w_rem_nxt;
               end
            end
         end
      end
   end

endmodule
